hack_cpu: RTL
=============

// Module: hack_cpu
// PURPOSE
//  Single-cycle Hack CPU core: decodes a 16-bit instruction, holds the A, D and PC registers, and drives the ALU's x/y operands and six control bits.
//  Consumes ALU out/zr/ng to write back to A/D/memory and to decide jumps.
//  Sits between instruction ROM (pc -> instruction) and data RAM (addressM/outM/writeM/inM).
// PARAMETERS
//  RESET_PC  15'h0000  value loaded into pc on reset
// PORTS
//  clk          in   1   single system clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  instruction  in   16  instruction fetched from ROM[pc]
//  inM          in   16  data read from RAM[addressM]
//  outM         out  16  ALU result, data to write to RAM
//  writeM       out  1   RAM write enable for current cycle
//  addressM     out  15  RAM address = A[14:0]
//  pc           out  15  address of next instruction to fetch
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset is synchronous and active-high.
//  - Registers: A (16b), D (16b) and PC (15b). On reset at a clk edge: A=0, D=0, PC=RESET_PC.
//    writeM is forced to 0 whenever reset=1, including the same cycle it is asserted.
//  - A-instruction (instruction[15]=0): A <= instruction. No D write, writeM=0, PC <= PC+1.
//  - C-instruction (instruction[15]=1): bits[14:13] are ignored. Field layout:
//    - a    = [12]
//    - zx,nx,zy,ny,f,no = [11:6]
//    - d1,d2,d3 = [5:3] (destinations A, D, M)
//    - j1,j2,j3 = [2:0] (lt, eq, gt)
//  - ALU operands: x = D; y = a ? inM : A. Control bits come straight from [11:6]. The ALU path is combinational.
//  - A C-instruction's results: outM = ALU out (driven every cycle, don't-care when writeM=0). writeM = C & d3, combinational.
//    On the edge: A <= ALU out if C & d1; D <= ALU out if C & d2.
//  - Jump: take = C & ((j1&ng) | (j2&zr) | (j3&~ng&~zr)). If take, PC <= A[14:0], else PC <= PC+1.
//  - Ordering within one cycle: addressM, the jump target and y all use the pre-edge A.
//    Example: when d1 and a jump coincide, the jump goes to the old A and A takes the new value.
//  - Latency: outM/writeM/addressM are valid in the same cycle as instruction; A/D/PC update at the next edge.
//  - Wrap: PC+1 is mod 2^15, so 15'h7FFF -> 15'h0000. ALU arithmetic is mod 2^16 and overflow is discarded.
//  - Reset mid-program: it overrides every write and jump in that cycle. The cycle after release fetches RESET_PC.
//  - No stalls and no handshake: exactly one instruction retires per clock.
// STRUCTURE
//  - Shared package/header: opcode bit positions (IDX_TYPE=15, IDX_A=12, CTRL_HI=11..CTRL_LO=6, DEST_A/D/M=5/4/3, JMP_LT/EQ/GT=2/1/0) and WORD_W=16, ADDR_W=15.
//  - Instantiate the existing ALU unchanged as the compute stage.
//  - One new sub-module: hack_pc, a 15-bit register with priority reset > load > inc.
//  - Decode, A/D registers and jump logic stay in hack_cpu.
// TESTING
//  1. Hold reset 2 cycles, then release -> pc=0, A=0, D=0, writeM=0 while reset is high; pc=1 after the first free edge.
//  2. Run 0x0005 (@5), then 0xEC10 (D=A) -> A=5, D=5, pc=2, writeM=0 throughout.
//  3. D=5, then 0x0064 (@100), then 0xE7C8 (M=D+1) with inM=0xABCD -> writeM=1, addressM=100, outM=6 in that cycle.
//  4. Run 0xFC10 (D=M) with inM=0xFFFF -> D=0xFFFF.
//     Then 0x0014 (@20), then 0xE304 (D;JLT) -> pc=20. Repeat with D=0 -> no jump, pc=PC+1.
//  5. Set A=0x0030 and run 0xEA87 (0;JMP) -> pc=0x30.
//     With pc=0x7FFF and a non-jump instruction -> pc=0x0000.
//  6. Assert reset during an M=D+1 with JMP bits set -> writeM=0 that cycle; next pc=0, A=0, D=0.

Source files
------------

// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the Hack CPU: word/address widths, instruction field positions, decode helper.
// Latency: n/a (types, constants and a purely combinational function).
// Backpressure: n/a.
// Contents: WORD_W/ADDR_W, IDX_* bit positions, alu_ctrl_t, dec_t, decode().
package hack_cpu_pkg;

    localparam int WORD_W   = 16;
    localparam int ADDR_W   = 15;

    // Instruction field positions
    localparam int IDX_TYPE = 15;
    localparam int IDX_A    = 12;
    localparam int CTRL_HI  = 11;
    localparam int CTRL_LO  = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LT   = 2;
    localparam int JMP_EQ   = 1;
    localparam int JMP_GT   = 0;

    // Six ALU control bits, in instruction order [11:6]
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef struct packed {
        logic      is_c;
        logic      a;
        alu_ctrl_t ctrl;
        logic      d_a;
        logic      d_d;
        logic      d_m;
        logic      j_lt;
        logic      j_eq;
        logic      j_gt;
    } dec_t;

    // Field extraction only; bits [14:13] carry no meaning and are dropped.
    // Destination and jump bits are gated with the C flag so an A-instruction
    // whose value happens to have those bits set never writes or jumps.
    function automatic dec_t decode(input logic [WORD_W-1:0] instr);
        dec_t d;
        d.is_c = instr[IDX_TYPE];
        d.a    = instr[IDX_A];
        d.ctrl = alu_ctrl_t'(instr[CTRL_HI:CTRL_LO]);
        d.d_a  = instr[IDX_TYPE] & instr[DEST_A];
        d.d_d  = instr[IDX_TYPE] & instr[DEST_D];
        d.d_m  = instr[IDX_TYPE] & instr[DEST_M];
        d.j_lt = instr[IDX_TYPE] & instr[JMP_LT];
        d.j_eq = instr[IDX_TYPE] & instr[JMP_EQ];
        d.j_gt = instr[IDX_TYPE] & instr[JMP_GT];
        return d;
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: computes f(x, y) under the six control bits and flags zero/negative results.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: x, y (operands), zx/nx/zy/ny/f/no (control), out (result), zr (out==0), ng (out<0).
module hack_alu
    import hack_cpu_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              zx,
    input  logic              nx,
    input  logic              zy,
    input  logic              ny,
    input  logic              f,
    input  logic              no,
    output logic [WORD_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [WORD_W-1:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = zx ? '0 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? '0 : y;
        y_n = ny ? ~y_z : y_z;
        // Sum is mod 2^16; carry out is simply dropped.
        res = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~res : res;
        zr  = (out == '0);
        ng  = out[WORD_W-1];
    end

endmodule

// File: rtl/hack_pc.sv
// Program counter register with priority reset > load > increment.
// Latency: one cycle; q reflects the decision taken at the previous rising edge.
// Backpressure: none; updates every clock.
// Ports: clk, reset (sync, active-high), load/din (jump target), inc (advance), q (current pc).
module hack_pc
    import hack_cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] din,
    input  logic              inc,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= din;
        end else if (inc) begin
            // 15-bit add wraps 7FFF -> 0000 naturally.
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: decode, A/D registers, jump logic, ALU and PC.
// Latency: outM/writeM/addressM combinational from instruction; A/D/pc update at the next rising edge.
// Backpressure: none; exactly one instruction retires per clock, no stalls.
// Ports: clk, reset (sync, active-high), instruction (ROM[pc]), inM (RAM[addressM]),
//        outM (ALU result), writeM (RAM write enable), addressM (A[14:0]), pc (next fetch address).
module hack_cpu
    import hack_cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 15'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] instruction,
    input  logic [WORD_W-1:0] inM,
    output logic [WORD_W-1:0] outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc
);

    dec_t              dec;
    logic [WORD_W-1:0] a_reg;
    logic [WORD_W-1:0] d_reg;
    logic [WORD_W-1:0] alu_y;
    logic [WORD_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;
    logic              take;
    logic              unused_bits;

    assign dec         = decode(instruction);
    assign unused_bits = ^instruction[14:13];

    // y, addressM and the jump target all see the A value from before the edge.
    assign alu_y = dec.a ? inM : a_reg;

    hack_alu u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (dec.ctrl.zx),
        .nx  (dec.ctrl.nx),
        .zy  (dec.ctrl.zy),
        .ny  (dec.ctrl.ny),
        .f   (dec.ctrl.f),
        .no  (dec.ctrl.no),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign outM     = alu_out;
    assign addressM = a_reg[ADDR_W-1:0];
    // Reset masks the RAM write in the very cycle it is raised, not just after the edge.
    assign writeM   = dec.d_m & ~reset;

    // Jump bits are already gated by is_c in decode.
    assign take = (dec.j_lt & alu_ng)
                | (dec.j_eq & alu_zr)
                | (dec.j_gt & ~alu_ng & ~alu_zr);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            d_reg <= '0;
        end else begin
            if (!dec.is_c) begin
                a_reg <= instruction;
            end else if (dec.d_a) begin
                a_reg <= alu_out;
            end
            if (dec.d_d) begin
                d_reg <= alu_out;
            end
        end
    end

    hack_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (take),
        .din   (a_reg[ADDR_W-1:0]),
        .inc   (1'b1),
        .q     (pc)
    );

endmodule
